// File: rtl/pcpi_nib_pkg.sv
// Shared definitions for the nibble-serial PCPI pin links (transmit result / receive instruction).
package pcpi_nib_pkg;

  localparam int NIB_W_DEF  = 4;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PRESENT = 2'd2,
    RELEASE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/pcpi_nib_bit_sync.sv
// N-flop synchronizer for a single asynchronous pin; the output is the last flop.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // shift the pin level through the synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pcpi_result_nibble_tx.sv
// Captures a PCPI result word and shifts it off-chip LSB nibble first over a
// four-phase valid/ack pin handshake.
module pcpi_result_nibble_tx
  import pcpi_nib_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NIB_W       = NIB_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcpi_ready,
  input  logic              pcpi_wr,
  input  logic [DATA_W-1:0] pcpi_rd,
  output logic [NIB_W-1:0]  tx_data,
  output logic              tx_valid,
  input  logic              tx_ack,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int NIBS  = DATA_W / NIB_W;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

  tx_state_t          state_r, state_nxt_s;
  logic               ack_s;
  logic               capture_s;
  logic               last_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s;
  logic [DATA_W-1:0]  sh_r, sh_nxt_s, sh_shift_s;
  logic [NIB_W-1:0]   tx_data_r, data_nxt_s;
  logic               tx_valid_r;
  logic               busy_r;
  logic               done_r;
  logic               overrun_r;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (tx_ack),
    .q   (ack_s)
  );

  assign capture_s  = pcpi_ready && pcpi_wr;
  assign last_s     = (idx_r == LAST_IDX);
  assign sh_shift_s = sh_r >> NIB_W;

  // next state plus the shift register, index and pin nibble that go with it
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    sh_nxt_s    = sh_r;
    data_nxt_s  = tx_data_r;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          sh_nxt_s  = pcpi_rd;
          idx_nxt_s = '0;
          if (ack_s) begin
            state_nxt_s = ARM;
          end else begin
            state_nxt_s = PRESENT;
            data_nxt_s  = pcpi_rd[NIB_W-1:0];
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARM: begin
        // host still holds an ack from before; wait for it to clear
        if (!ack_s) begin
          state_nxt_s = PRESENT;
          data_nxt_s  = sh_r[NIB_W-1:0];
        end else begin
          state_nxt_s = ARM;
        end
      end
      PRESENT: begin
        if (ack_s) begin
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = PRESENT;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          if (last_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = PRESENT;
            sh_nxt_s    = sh_shift_s;
            idx_nxt_s   = idx_r + IDX_W'(1);
            data_nxt_s  = sh_shift_s[NIB_W-1:0];
          end
        end else begin
          state_nxt_s = RELEASE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // state, datapath and registered pin/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      sh_r       <= '0;
      tx_data_r  <= '0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      sh_r       <= sh_nxt_s;
      tx_data_r  <= data_nxt_s;
      tx_valid_r <= (state_nxt_s == PRESENT);
      busy_r     <= (state_nxt_s != IDLE);
      done_r     <= (state_r == RELEASE) && (state_nxt_s == IDLE);
      if (capture_s && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign overrun  = overrun_r;

endmodule
